// File: rtl/apb_requester_pkg.sv
// Shared types and default constants for the APB command requester.
package apb_requester_pkg;

  // APB data path width; the requester supports only this width.
  localparam int unsigned ApbDataWidth = 32;

  // Default ACCESS-phase wait limit (cycles with pready low).
  localparam int unsigned DefaultTimeoutCycles = 256;

  // Width of the ACCESS-phase wait counter.
  localparam int unsigned TimeoutCntWidth = 16;

  // Requester transfer FSM.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } req_state_e;

endpackage

// File: rtl/apb_cmd_requester.sv
// APB requester: turns a valid/ready command into one APB transfer and returns
// the result on a valid/ready response channel.
// Optional feature macro: APB_REQUESTER_TIMEOUT_EN bounds the ACCESS phase to
// TIMEOUT_CYCLES cycles of pready=0 and reports a timeout error response.
module apb_cmd_requester
  import apb_requester_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = ApbDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                  pclk,
  input  logic                  rst,
  // Command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_strb,
  // Response channel
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,
  // APB requester
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [3:0]            pstrb,
  output logic [2:0]            pprot,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  // Elaboration-time parameter guards.
  if (DATA_WIDTH != ApbDataWidth) begin : g_bad_data_width
    $error("apb_cmd_requester: DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_cmd_requester: TIMEOUT_CYCLES must be in 2..65535");
  end

  req_state_e            r_state;
  req_state_e            w_state_d;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_strb;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_timeout_hit;

  assign w_accept   = (r_state == StIdle) && cmd_valid;
  // pready is only meaningful during ACCESS; it wins over a same-cycle timeout.
  assign w_complete = (r_state == StAccess) && pready;

`ifdef APB_REQUESTER_TIMEOUT_EN
  logic [TimeoutCntWidth-1:0] r_cnt;
  logic [TimeoutCntWidth-1:0] w_cnt_inc;
  logic                       r_timeout;

  assign w_cnt_inc     = r_cnt + 16'd1;
  // Fires on the TIMEOUT_CYCLES-th ACCESS cycle that still sees pready=0.
  assign w_timeout_hit = (r_state == StAccess) && !pready &&
                         (w_cnt_inc == 16'(TIMEOUT_CYCLES));

  // Wait counter (cleared in SETUP so it starts at zero on ACCESS entry) and timeout flag.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == StSetup) begin
        r_cnt <= '0;
      end else if ((r_state == StAccess) && !pready) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_complete) begin
        r_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign resp_timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign resp_timeout  = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (cmd_valid) w_state_d = StSetup;
      StSetup:  w_state_d = StAccess;
      StAccess: if (pready || w_timeout_hit) w_state_d = StResp;
      StResp:   if (resp_ready) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Command capture on acceptance and response capture on ACCESS completion.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        // Reads carry no byte lanes.
        r_strb  <= cmd_write ? cmd_strb : 4'b0000;
      end
      if (w_complete) begin
        r_rdata <= r_write ? '0 : prdata;
        r_err   <= pslverr;
      end else if (w_timeout_hit) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign cmd_ready  = (r_state == StIdle);
  assign psel       = (r_state == StSetup) || (r_state == StAccess);
  assign penable    = (r_state == StAccess);
  assign pwrite     = r_write;
  assign paddr      = r_addr;
  assign pwdata     = r_wdata;
  assign pstrb      = r_strb;
  assign pprot      = 3'b000;
  assign resp_valid = (r_state == StResp);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
